// File: rtl/rob_pkg.sv
// rob_pkg: shared types and constants for the reorder buffer.
//   rob_inst_t   - per-entry dispatch info (areg, pc, w_reg, w_mem)
//   rob_data_t   - per-entry result (data, exc)
//   rob_commit_t - commit lane payload (inst info + result)
//   rob_ptr_w()  - head/tail pointer width for a given depth (index bits + wrap bit)
//   ROB_DEPTH    - default entry count
package rob_pkg;

    localparam int unsigned ROB_DEPTH  = 64;
    localparam int unsigned ROB_DATA_W = 32;
    localparam int unsigned ROB_AREG_W = 5;
    localparam int unsigned ROB_PC_W   = 32;

    typedef struct packed {
        logic [ROB_AREG_W-1:0] areg;
        logic [ROB_PC_W-1:0]   pc;
        logic                  w_reg;
        logic                  w_mem;
    } rob_inst_t;

    typedef struct packed {
        logic [ROB_DATA_W-1:0] data;
        logic                  exc;
    } rob_data_t;

    typedef struct packed {
        logic [ROB_AREG_W-1:0] areg;
        logic [ROB_PC_W-1:0]   pc;
        logic                  w_reg;
        logic                  w_mem;
        logic [ROB_DATA_W-1:0] data;
        logic                  exc;
    } rob_commit_t;

    // Pointer carries one extra MSB as the wrap bit.
    function automatic int unsigned rob_ptr_w(input int unsigned depth);
        return $clog2(depth) + 1;
    endfunction

    typedef logic [rob_ptr_w(ROB_DEPTH)-1:0] rob_ptr_t;

endpackage

// File: rtl/rob_mp_regfile.sv
// rob_mp_regfile: register array with N_RD combinational read ports and N_WR write ports.
//   clk   in  : clock
//   we    in  : per-lane write enable mask
//   waddr in  : per-lane write index
//   wdata in  : per-lane write data
//   raddr in  : per-port read index
//   rdata out : per-port read data (asynchronous read of stored state)
// No reset: contents are don't-care until written. If two lanes hit the same index in one
// cycle the higher-numbered lane wins; callers treat that case as illegal anyway.
module rob_mp_regfile #(
    parameter int unsigned DEPTH = 64,
    parameter int unsigned WIDTH = 32,
    parameter int unsigned N_RD  = 2,
    parameter int unsigned N_WR  = 2,
    localparam int unsigned AW   = $clog2(DEPTH)
) (
    input  logic                       clk,
    input  logic [N_WR-1:0]            we,
    input  logic [N_WR-1:0][AW-1:0]    waddr,
    input  logic [N_WR-1:0][WIDTH-1:0] wdata,
    input  logic [N_RD-1:0][AW-1:0]    raddr,
    output logic [N_RD-1:0][WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        for (int w = 0; w < int'(N_WR); w++) begin
            if (we[w]) begin
                mem_q[waddr[w]] <= wdata[w];
            end
        end
    end

    always_comb begin
        for (int r = 0; r < int'(N_RD); r++) begin
            rdata[r] = mem_q[raddr[r]];
        end
    end

endmodule

// File: rtl/reorder_buffer.sv
// reorder_buffer: circular in-order-retire buffer between dispatch, CDB writeback and commit.
//   clk, rst_n      : clock, synchronous active-low reset
//   flush_i         : empty the buffer at the next edge
//   disp_*          : program-order allocation (valid lanes packed from lane 0), assigned ids
//   src_*           : operand lookups for dispatch (data + complete flag)
//   cdb_*           : writeback strobes, target ids, results and exception flags
//   commit_*        : oldest completed entries (valid is a prefix) and prefix acks
//   count_o         : registered occupancy
// Build option: define ROB_CDB_BYPASS_EN to forward same-cycle CDB writes into the src
// lookups and commit lanes; otherwise every output comes from stored state.
module reorder_buffer
    import rob_pkg::*;
#(
    parameter int unsigned DEPTH      = ROB_DEPTH,
    parameter int unsigned DISPATCH_W = 2,
    parameter int unsigned COMMIT_W   = 2,
    parameter int unsigned CDB_W      = 2,
    parameter int unsigned DATA_W     = ROB_DATA_W,
    localparam int unsigned ID_W      = $clog2(DEPTH)
) (
    input  logic                                  clk,
    input  logic                                  rst_n,
    input  logic                                  flush_i,
    input  logic [DISPATCH_W-1:0]                 disp_valid_i,
    output logic                                  disp_ready_o,
    input  rob_inst_t [DISPATCH_W-1:0]            disp_info_i,
    output logic [DISPATCH_W-1:0][ID_W-1:0]       disp_id_o,
    input  logic [DISPATCH_W-1:0][1:0][ID_W-1:0]  src_id_i,
    output logic [DISPATCH_W-1:0][1:0][DATA_W-1:0] src_data_o,
    output logic [DISPATCH_W-1:0][1:0]            src_complete_o,
    input  logic [CDB_W-1:0]                      cdb_valid_i,
    input  logic [CDB_W-1:0][ID_W-1:0]            cdb_id_i,
    input  logic [CDB_W-1:0][DATA_W-1:0]          cdb_data_i,
    input  logic [CDB_W-1:0]                      cdb_exc_i,
    output logic [COMMIT_W-1:0]                   commit_valid_o,
    output rob_commit_t [COMMIT_W-1:0]            commit_info_o,
    input  logic [COMMIT_W-1:0]                   commit_ack_i,
    output logic [ID_W:0]                         count_o
);

    localparam int unsigned PTR_W = rob_ptr_w(DEPTH);
    localparam int unsigned NSRC  = DISPATCH_W * 2;
    localparam int unsigned N_DRD = NSRC + COMMIT_W;
    localparam int unsigned INST_W = $bits(rob_inst_t);

    typedef logic [PTR_W-1:0] ptr_t;

    ptr_t head_q, head_d, tail_q, tail_d, count_q, count_d;
    logic [DEPTH-1:0] complete_q, complete_d, exc_q, exc_d;

    logic                  disp_ready;
    logic [DISPATCH_W-1:0] disp_acc;
    ptr_t                  n_disp, n_ack, free_slots;

    logic [COMMIT_W-1:0][ID_W-1:0]   commit_id;
    rob_inst_t [COMMIT_W-1:0]        inst_rd;
    logic [N_DRD-1:0][ID_W-1:0]      data_raddr;
    logic [N_DRD-1:0][DATA_W-1:0]    data_rd;
    logic [COMMIT_W-1:0]             cm_complete;
    rob_data_t [COMMIT_W-1:0]        cm_data;
    logic                            older_ok;

    // Ready depends only on registered count, so a same-cycle ack cannot reopen a full buffer.
    always_comb begin
        free_slots = ptr_t'(DEPTH) - count_q;
        disp_ready = (free_slots >= ptr_t'(DISPATCH_W));
        disp_acc   = disp_valid_i & {DISPATCH_W{disp_ready}};
        n_disp     = '0;
        for (int k = 0; k < int'(DISPATCH_W); k++) begin
            disp_id_o[k] = tail_q[ID_W-1:0] + ID_W'(k);
            n_disp       = n_disp + ptr_t'(disp_acc[k]);
        end
        n_ack = '0;
        for (int i = 0; i < int'(COMMIT_W); i++) begin
            commit_id[i] = head_q[ID_W-1:0] + ID_W'(i);
            n_ack        = n_ack + ptr_t'(commit_ack_i[i]);
        end
    end

    assign disp_ready_o = disp_ready;
    assign count_o      = count_q;

    rob_mp_regfile #(
        .DEPTH (DEPTH),
        .WIDTH (INST_W),
        .N_RD  (COMMIT_W),
        .N_WR  (DISPATCH_W)
    ) u_inst_table (
        .clk   (clk),
        .we    (disp_acc),
        .waddr (disp_id_o),
        .wdata (disp_info_i),
        .raddr (commit_id),
        .rdata (inst_rd)
    );

    always_comb begin
        for (int k = 0; k < int'(DISPATCH_W); k++) begin
            for (int o = 0; o < 2; o++) begin
                data_raddr[k*2+o] = src_id_i[k][o];
            end
        end
        for (int i = 0; i < int'(COMMIT_W); i++) begin
            data_raddr[NSRC+i] = commit_id[i];
        end
    end

    rob_mp_regfile #(
        .DEPTH (DEPTH),
        .WIDTH (DATA_W),
        .N_RD  (N_DRD),
        .N_WR  (CDB_W)
    ) u_data_table (
        .clk   (clk),
        .we    (cdb_valid_i),
        .waddr (cdb_id_i),
        .wdata (cdb_data_i),
        .raddr (data_raddr),
        .rdata (data_rd)
    );

    // Operand lookups.
    always_comb begin
        for (int k = 0; k < int'(DISPATCH_W); k++) begin
            for (int o = 0; o < 2; o++) begin
                src_data_o[k][o]     = data_rd[k*2+o];
                src_complete_o[k][o] = complete_q[src_id_i[k][o]];
`ifdef ROB_CDB_BYPASS_EN
                for (int p = 0; p < int'(CDB_W); p++) begin
                    if (cdb_valid_i[p] && (cdb_id_i[p] == src_id_i[k][o])) begin
                        src_data_o[k][o]     = cdb_data_i[p];
                        src_complete_o[k][o] = 1'b1;
                    end
                end
`endif
            end
        end
    end

    // Commit lanes: a lane is valid only if every older lane is valid and exception-free,
    // so an exception entry retires alone at its lane.
    always_comb begin
        older_ok = 1'b1;
        for (int i = 0; i < int'(COMMIT_W); i++) begin
            cm_complete[i]  = complete_q[commit_id[i]];
            cm_data[i].data = ROB_DATA_W'(data_rd[NSRC+i]);
            cm_data[i].exc  = exc_q[commit_id[i]];
`ifdef ROB_CDB_BYPASS_EN
            for (int p = 0; p < int'(CDB_W); p++) begin
                if (cdb_valid_i[p] && (cdb_id_i[p] == commit_id[i])) begin
                    cm_complete[i]  = 1'b1;
                    cm_data[i].data = ROB_DATA_W'(cdb_data_i[p]);
                    cm_data[i].exc  = cm_data[i].exc | cdb_exc_i[p];
                end
            end
`endif
            commit_valid_o[i]      = older_ok && (ptr_t'(i) < count_q) && cm_complete[i];
            commit_info_o[i].areg  = inst_rd[i].areg;
            commit_info_o[i].pc    = inst_rd[i].pc;
            commit_info_o[i].w_reg = inst_rd[i].w_reg;
            commit_info_o[i].w_mem = inst_rd[i].w_mem;
            commit_info_o[i].data  = cm_data[i].data;
            commit_info_o[i].exc   = cm_data[i].exc;
            older_ok               = commit_valid_o[i] && !cm_data[i].exc;
        end
    end

    // Next state; flush overrides dispatch, writeback and ack.
    always_comb begin
        head_d     = head_q + n_ack;
        tail_d     = tail_q + n_disp;
        count_d    = count_q + n_disp - n_ack;
        complete_d = complete_q;
        exc_d      = exc_q;
        for (int k = 0; k < int'(DISPATCH_W); k++) begin
            if (disp_acc[k]) begin
                complete_d[disp_id_o[k]] = 1'b0;
                exc_d[disp_id_o[k]]      = 1'b0;
            end
        end
        for (int p = 0; p < int'(CDB_W); p++) begin
            if (cdb_valid_i[p]) begin
                complete_d[cdb_id_i[p]] = 1'b1;
                exc_d[cdb_id_i[p]]      = exc_d[cdb_id_i[p]] | cdb_exc_i[p];
            end
        end
        if (flush_i) begin
            head_d     = '0;
            tail_d     = '0;
            count_d    = '0;
            complete_d = '0;
            exc_d      = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            head_q     <= '0;
            tail_q     <= '0;
            count_q    <= '0;
            complete_q <= '0;
            exc_q      <= '0;
        end else begin
            head_q     <= head_d;
            tail_q     <= tail_d;
            count_q    <= count_d;
            complete_q <= complete_d;
            exc_q      <= exc_d;
        end
    end

    // Protocol checks on writeback and ack usage.
    for (genvar p = 0; p < int'(CDB_W); p++) begin : g_cdb_chk
        logic [ID_W-1:0] offs;
        assign offs = cdb_id_i[p] - head_q[ID_W-1:0];

        a_cdb_alloc: assert property (@(posedge clk) disable iff (!rst_n || flush_i)
            cdb_valid_i[p] |-> ({1'b0, offs} < count_q));

        for (genvar q = p + 1; q < int'(CDB_W); q++) begin : g_pair
            a_cdb_dup: assert property (@(posedge clk) disable iff (!rst_n || flush_i)
                (cdb_valid_i[p] && cdb_valid_i[q]) |-> (cdb_id_i[p] != cdb_id_i[q]));
        end
    end

    a_ack_subset: assert property (@(posedge clk) disable iff (!rst_n || flush_i)
        (commit_ack_i & ~commit_valid_o) == '0);

    a_ack_prefix: assert property (@(posedge clk) disable iff (!rst_n || flush_i)
        ((commit_ack_i + COMMIT_W'(1)) & commit_ack_i) == '0);

endmodule

// File: tb/tb_reorder_buffer.sv
// tb_reorder_buffer: directed self-checking bench for reorder_buffer (DEPTH=64, 2/2/2 lanes).
// Inputs change 1 time unit after the rising edge; outputs are checked 1 unit later.
module tb_reorder_buffer;
    import rob_pkg::*;

    localparam int unsigned DEPTH  = 64;
    localparam int unsigned DW     = 2;
    localparam int unsigned CW     = 2;
    localparam int unsigned CDBW   = 2;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned ID_W   = 6;

    logic clk = 1'b0;
    logic rst_n, flush_i;
    logic [DW-1:0] disp_valid_i;
    logic disp_ready_o;
    rob_inst_t [DW-1:0] disp_info_i;
    logic [DW-1:0][ID_W-1:0] disp_id_o;
    logic [DW-1:0][1:0][ID_W-1:0] src_id_i;
    logic [DW-1:0][1:0][DATA_W-1:0] src_data_o;
    logic [DW-1:0][1:0] src_complete_o;
    logic [CDBW-1:0] cdb_valid_i;
    logic [CDBW-1:0][ID_W-1:0] cdb_id_i;
    logic [CDBW-1:0][DATA_W-1:0] cdb_data_i;
    logic [CDBW-1:0] cdb_exc_i;
    logic [CW-1:0] commit_valid_o;
    rob_commit_t [CW-1:0] commit_info_o;
    logic [CW-1:0] commit_ack_i;
    logic [ID_W:0] count_o;

    int n_pass = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    reorder_buffer #(
        .DEPTH      (DEPTH),
        .DISPATCH_W (DW),
        .COMMIT_W   (CW),
        .CDB_W      (CDBW),
        .DATA_W     (DATA_W)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .flush_i        (flush_i),
        .disp_valid_i   (disp_valid_i),
        .disp_ready_o   (disp_ready_o),
        .disp_info_i    (disp_info_i),
        .disp_id_o      (disp_id_o),
        .src_id_i       (src_id_i),
        .src_data_o     (src_data_o),
        .src_complete_o (src_complete_o),
        .cdb_valid_i    (cdb_valid_i),
        .cdb_id_i       (cdb_id_i),
        .cdb_data_i     (cdb_data_i),
        .cdb_exc_i      (cdb_exc_i),
        .commit_valid_o (commit_valid_o),
        .commit_info_o  (commit_info_o),
        .commit_ack_i   (commit_ack_i),
        .count_o        (count_o)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        flush_i      = 1'b0;
        disp_valid_i = '0;
        disp_info_i  = '0;
        src_id_i     = '0;
        cdb_valid_i  = '0;
        cdb_id_i     = '0;
        cdb_data_i   = '0;
        cdb_exc_i    = '0;
        commit_ack_i = '0;
    endtask

    // Lane k carries the instruction expected at id base+k; pc encodes that id.
    task automatic set_disp(input logic [DW-1:0] v, input int base);
        disp_valid_i = v;
        for (int k = 0; k < int'(DW); k++) begin
            disp_info_i[k].areg  = 5'((base + k) % 32);
            disp_info_i[k].pc    = 32'h1000 + 32'(4 * (base + k));
            disp_info_i[k].w_reg = 1'b1;
            disp_info_i[k].w_mem = 1'b0;
        end
    endtask

    task automatic set_cdb(input int p, input int id, input logic [31:0] d, input logic e);
        cdb_valid_i[p] = 1'b1;
        cdb_id_i[p]    = ID_W'(id);
        cdb_data_i[p]  = d;
        cdb_exc_i[p]   = e;
    endtask

    task automatic test_reset();
        clear_inputs();
        rst_n = 1'b0;
        step();
        step();
        rst_n = 1'b1;
        src_id_i[0][0] = 6'd0;
        src_id_i[0][1] = 6'd1;
        src_id_i[1][0] = 6'd2;
        src_id_i[1][1] = 6'd63;
        #1;
        n_total++; if (disp_ready_o !== 1'b1) $display("FAIL reset_ready: got %b want 1", disp_ready_o); else n_pass++;
        n_total++; if (commit_valid_o !== 2'b00) $display("FAIL reset_commit_valid: got %b want 00", commit_valid_o); else n_pass++;
        n_total++; if (count_o !== 7'd0) $display("FAIL reset_count: got %0d want 0", count_o); else n_pass++;
        n_total++; if (src_complete_o !== 4'b0000) $display("FAIL reset_src_complete: got %b want 0000", src_complete_o); else n_pass++;
        n_total++; if (disp_id_o[0] !== 6'd0) $display("FAIL reset_disp_id0: got %0d want 0", disp_id_o[0]); else n_pass++;
        n_total++; if (disp_id_o[1] !== 6'd1) $display("FAIL reset_disp_id1: got %0d want 1", disp_id_o[1]); else n_pass++;
        clear_inputs();
    endtask

    task automatic test_fill();
        for (int c = 0; c < 32; c++) begin
            set_disp(2'b11, 2 * c);
            #1;
            n_total++; if (disp_id_o[0] !== 6'(2 * c)) $display("FAIL fill_id0[%0d]: got %0d want %0d", c, disp_id_o[0], 2 * c); else n_pass++;
            n_total++; if (disp_id_o[1] !== 6'(2 * c + 1)) $display("FAIL fill_id1[%0d]: got %0d want %0d", c, disp_id_o[1], 2 * c + 1); else n_pass++;
            n_total++; if (count_o !== 7'(2 * c)) $display("FAIL fill_count[%0d]: got %0d want %0d", c, count_o, 2 * c); else n_pass++;
            n_total++; if (disp_ready_o !== 1'b1) $display("FAIL fill_ready[%0d]: got %b want 1", c, disp_ready_o); else n_pass++;
            n_total++; if (commit_valid_o !== 2'b00) $display("FAIL fill_commit[%0d]: got %b want 00", c, commit_valid_o); else n_pass++;
            step();
        end
        clear_inputs();
        #1;
        n_total++; if (count_o !== 7'd64) $display("FAIL full_count: got %0d want 64", count_o); else n_pass++;
        n_total++; if (disp_ready_o !== 1'b0) $display("FAIL full_ready: got %b want 0", disp_ready_o); else n_pass++;
        n_total++; if (commit_valid_o !== 2'b00) $display("FAIL full_commit: got %b want 00", commit_valid_o); else n_pass++;
        flush_i = 1'b1;
        step();
        flush_i = 1'b0;
    endtask

    task automatic test_inorder();
        logic [1:0] exp_same;
`ifdef ROB_CDB_BYPASS_EN
        exp_same = 2'b11;
`else
        exp_same = 2'b00;
`endif
        set_disp(2'b11, 0);
        step();
        clear_inputs();
        set_cdb(0, 1, 32'hBEEF, 1'b0);
        src_id_i[0][0] = 6'd1;
        #1;
        n_total++; if (commit_valid_o !== 2'b00) $display("FAIL inorder_young_only: got %b want 00", commit_valid_o); else n_pass++;
        step();
        set_cdb(0, 0, 32'h1234, 1'b0);
        #1;
        n_total++; if (src_complete_o[0][0] !== 1'b1) $display("FAIL inorder_src_complete: got %b want 1", src_complete_o[0][0]); else n_pass++;
        n_total++; if (src_data_o[0][0] !== 32'hBEEF) $display("FAIL inorder_src_data: got %h want BEEF", src_data_o[0][0]); else n_pass++;
        n_total++; if (commit_valid_o !== exp_same) $display("FAIL inorder_same_cycle: got %b want %b", commit_valid_o, exp_same); else n_pass++;
        step();
        cdb_valid_i = '0;
        #1;
        n_total++; if (commit_valid_o !== 2'b11) $display("FAIL inorder_valid: got %b want 11", commit_valid_o); else n_pass++;
        n_total++; if (commit_info_o[0].data !== 32'h1234) $display("FAIL inorder_data0: got %h want 1234", commit_info_o[0].data); else n_pass++;
        n_total++; if (commit_info_o[1].data !== 32'hBEEF) $display("FAIL inorder_data1: got %h want BEEF", commit_info_o[1].data); else n_pass++;
        n_total++; if (commit_info_o[0].pc !== 32'h1000) $display("FAIL inorder_pc0: got %h want 1000", commit_info_o[0].pc); else n_pass++;
        n_total++; if (commit_info_o[1].pc !== 32'h1004) $display("FAIL inorder_pc1: got %h want 1004", commit_info_o[1].pc); else n_pass++;
        n_total++; if (commit_info_o[0].exc !== 1'b0) $display("FAIL inorder_exc0: got %b want 0", commit_info_o[0].exc); else n_pass++;
        commit_ack_i = 2'b11;
        step();
        commit_ack_i = 2'b00;
        #1;
        n_total++; if (count_o !== 7'd0) $display("FAIL inorder_drained: got %0d want 0", count_o); else n_pass++;
        n_total++; if (commit_valid_o !== 2'b00) $display("FAIL inorder_empty_commit: got %b want 00", commit_valid_o); else n_pass++;
        clear_inputs();
    endtask

    task automatic test_exception();
        set_disp(2'b11, 2);
        step();
        clear_inputs();
        set_cdb(0, 2, 32'hDEAD, 1'b1);
        set_cdb(1, 3, 32'h3333, 1'b0);
        step();
        clear_inputs();
        #1;
        n_total++; if (commit_valid_o !== 2'b01) $display("FAIL exc_gate: got %b want 01", commit_valid_o); else n_pass++;
        n_total++; if (commit_info_o[0].exc !== 1'b1) $display("FAIL exc_flag: got %b want 1", commit_info_o[0].exc); else n_pass++;
        n_total++; if (commit_info_o[0].data !== 32'hDEAD) $display("FAIL exc_data: got %h want DEAD", commit_info_o[0].data); else n_pass++;
        commit_ack_i = 2'b01;
        step();
        commit_ack_i = 2'b00;
        #1;
        n_total++; if (commit_valid_o !== 2'b01) $display("FAIL exc_next_alone: got %b want 01", commit_valid_o); else n_pass++;
        n_total++; if (commit_info_o[0].data !== 32'h3333) $display("FAIL exc_next_data: got %h want 3333", commit_info_o[0].data); else n_pass++;
        n_total++; if (commit_info_o[0].pc !== 32'h100C) $display("FAIL exc_next_pc: got %h want 100C", commit_info_o[0].pc); else n_pass++;
        n_total++; if (commit_info_o[0].exc !== 1'b0) $display("FAIL exc_next_flag: got %b want 0", commit_info_o[0].exc); else n_pass++;
        n_total++; if (count_o !== 7'd1) $display("FAIL exc_count: got %0d want 1", count_o); else n_pass++;
        commit_ack_i = 2'b01;
        step();
        commit_ack_i = 2'b00;
        #1;
        n_total++; if (count_o !== 7'd0) $display("FAIL exc_drained: got %0d want 0", count_o); else n_pass++;
    endtask

    task automatic test_wrap();
        flush_i = 1'b1;
        step();
        flush_i = 1'b0;
        for (int c = 0; c < 31; c++) begin
            set_disp(2'b11, 2 * c);
            step();
        end
        set_disp(2'b01, 62);
        step();
        clear_inputs();
        for (int c = 0; c < 3; c++) begin
            set_cdb(0, 2 * c, 32'(100 + 2 * c), 1'b0);
            set_cdb(1, 2 * c + 1, 32'(101 + 2 * c), 1'b0);
            step();
        end
        clear_inputs();
        #1;
        n_total++; if (count_o !== 7'd63) $display("FAIL wrap_count63: got %0d want 63", count_o); else n_pass++;
        n_total++; if (disp_ready_o !== 1'b0) $display("FAIL wrap_ready63: got %b want 0", disp_ready_o); else n_pass++;
        n_total++; if (disp_id_o[0] !== 6'd63) $display("FAIL wrap_id63: got %0d want 63", disp_id_o[0]); else n_pass++;
        n_total++; if (disp_id_o[1] !== 6'd0) $display("FAIL wrap_id0: got %0d want 0", disp_id_o[1]); else n_pass++;
        n_total++; if (commit_valid_o !== 2'b11) $display("FAIL wrap_commit01: got %b want 11", commit_valid_o); else n_pass++;
        commit_ack_i = 2'b11;
        step();
        commit_ack_i = 2'b00;
        #1;
        n_total++; if (count_o !== 7'd61) $display("FAIL wrap_count61: got %0d want 61", count_o); else n_pass++;
        n_total++; if (disp_ready_o !== 1'b1) $display("FAIL wrap_ready61: got %b want 1", disp_ready_o); else n_pass++;
        set_disp(2'b11, 63);
        commit_ack_i = 2'b11;
        #1;
        n_total++; if (commit_valid_o !== 2'b11) $display("FAIL wrap_commit23: got %b want 11", commit_valid_o); else n_pass++;
        step();
        clear_inputs();
        #1;
        n_total++; if (count_o !== 7'd61) $display("FAIL wrap_count_both: got %0d want 61", count_o); else n_pass++;
        n_total++; if (disp_id_o[0] !== 6'd1) $display("FAIL wrap_id_after0: got %0d want 1", disp_id_o[0]); else n_pass++;
        n_total++; if (disp_id_o[1] !== 6'd2) $display("FAIL wrap_id_after1: got %0d want 2", disp_id_o[1]); else n_pass++;
        set_disp(2'b01, 1);
        step();
        set_disp(2'b11, 2);
        step();
        clear_inputs();
        #1;
        n_total++; if (count_o !== 7'd64) $display("FAIL wrap_full_count: got %0d want 64", count_o); else n_pass++;
        n_total++; if (disp_ready_o !== 1'b0) $display("FAIL wrap_full_ready: got %b want 0", disp_ready_o); else n_pass++;
        n_total++; if (disp_id_o[0] !== 6'd4) $display("FAIL wrap_full_id: got %0d want 4", disp_id_o[0]); else n_pass++;
        n_total++; if (commit_valid_o !== 2'b11) $display("FAIL wrap_commit45: got %b want 11", commit_valid_o); else n_pass++;
        commit_ack_i = 2'b11;
        #1;
        n_total++; if (disp_ready_o !== 1'b0) $display("FAIL wrap_full_ack_ready: got %b want 0", disp_ready_o); else n_pass++;
        step();
        commit_ack_i = 2'b00;
        #1;
        n_total++; if (count_o !== 7'd62) $display("FAIL wrap_after_ack_count: got %0d want 62", count_o); else n_pass++;
        n_total++; if (disp_ready_o !== 1'b1) $display("FAIL wrap_after_ack_ready: got %b want 1", disp_ready_o); else n_pass++;
        flush_i = 1'b1;
        step();
        flush_i = 1'b0;
    endtask

    task automatic test_flush();
        for (int c = 0; c < 5; c++) begin
            set_disp(2'b11, 2 * c);
            step();
        end
        clear_inputs();
        #1;
        n_total++; if (count_o !== 7'd10) $display("FAIL flush_pre_count: got %0d want 10", count_o); else n_pass++;
        flush_i = 1'b1;
        set_disp(2'b11, 10);
        set_cdb(0, 0, 32'h77, 1'b0);
        step();
        clear_inputs();
        src_id_i[0][0] = 6'd0;
        #1;
        n_total++; if (count_o !== 7'd0) $display("FAIL flush_count: got %0d want 0", count_o); else n_pass++;
        n_total++; if (disp_ready_o !== 1'b1) $display("FAIL flush_ready: got %b want 1", disp_ready_o); else n_pass++;
        n_total++; if (commit_valid_o !== 2'b00) $display("FAIL flush_commit: got %b want 00", commit_valid_o); else n_pass++;
        n_total++; if (disp_id_o[0] !== 6'd0) $display("FAIL flush_id0: got %0d want 0", disp_id_o[0]); else n_pass++;
        n_total++; if (disp_id_o[1] !== 6'd1) $display("FAIL flush_id1: got %0d want 1", disp_id_o[1]); else n_pass++;
        n_total++; if (src_complete_o[0][0] !== 1'b0) $display("FAIL flush_complete: got %b want 0", src_complete_o[0][0]); else n_pass++;
        set_disp(2'b11, 0);
        step();
        clear_inputs();
        #1;
        n_total++; if (count_o !== 7'd2) $display("FAIL flush_refill: got %0d want 2", count_o); else n_pass++;
    endtask

    task automatic test_bypass();
        logic [1:0] exp_cv;
        logic       exp_sc;
`ifdef ROB_CDB_BYPASS_EN
        exp_cv = 2'b01;
        exp_sc = 1'b1;
`else
        exp_cv = 2'b00;
        exp_sc = 1'b0;
`endif
        set_cdb(0, 0, 32'h55, 1'b0);
        src_id_i[1][1] = 6'd0;
        #1;
        n_total++; if (commit_valid_o !== exp_cv) $display("FAIL bypass_commit_same: got %b want %b", commit_valid_o, exp_cv); else n_pass++;
        n_total++; if (src_complete_o[1][1] !== exp_sc) $display("FAIL bypass_src_same: got %b want %b", src_complete_o[1][1], exp_sc); else n_pass++;
        step();
        cdb_valid_i = '0;
        #1;
        n_total++; if (commit_valid_o !== 2'b01) $display("FAIL bypass_commit_next: got %b want 01", commit_valid_o); else n_pass++;
        n_total++; if (commit_info_o[0].data !== 32'h55) $display("FAIL bypass_data: got %h want 55", commit_info_o[0].data); else n_pass++;
        n_total++; if (src_data_o[1][1] !== 32'h55) $display("FAIL bypass_src_data: got %h want 55", src_data_o[1][1]); else n_pass++;
        commit_ack_i = 2'b01;
        step();
        commit_ack_i = 2'b00;
        #1;
        n_total++; if (count_o !== 7'd1) $display("FAIL bypass_count: got %0d want 1", count_o); else n_pass++;
        clear_inputs();
    endtask

    initial begin
        test_reset();
        test_fill();
        test_inorder();
        test_exception();
        test_wrap();
        test_flush();
        test_bypass();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/reorder_buffer.md
# reorder_buffer

Parametrised circular reorder buffer for the out-of-order backend. It sits between rename/dispatch, the CDB, and the commit stage. It allocates entries in program order with a ready/valid handshake, captures results and exception flags from `CDB_W` writeback ports, and serves operand reads to dispatch. It presents the oldest in-order completed entries to commit. Depth, dispatch, commit and CDB widths are generic; full/empty tracking, backpressure and exception-gated commit are built in.

## Interface
Parameters:
- `DEPTH`, 64: entry count; power of two, ≥ 4.
- `DISPATCH_W`, 2: dispatch lanes; each lane has two operand read ports.
- `COMMIT_W`, 2: commit lanes.
- `CDB_W`, 2: writeback ports.
- `DATA_W`, 32: result width.
- `ID_W`, `$clog2(DEPTH)`: entry index width (derived).

Ports (reset `rst_n`: synchronous, active-low; clock `clk`):
- `clk` in 1: clock.
- `rst_n` in 1: synchronous active-low reset.
- `flush_i` in 1: empties the buffer at the next edge.
- `disp_valid_i` in DISPATCH_W: lane requests; lanes are packed from lane 0.
- `disp_ready_o` out 1: all DISPATCH_W lanes may allocate this cycle.
- `disp_info_i` in DISPATCH_W×`rob_inst_t`: areg, pc, w_reg, w_mem.
- `disp_id_o` out DISPATCH_W×ID_W: index assigned to each lane; combinational from tail.
- `src_id_i` in DISPATCH_W×2×ID_W: operand lookup indices.
- `src_data_o` out DISPATCH_W×2×DATA_W: lookup data.
- `src_complete_o` out DISPATCH_W×2: lookup entry complete.
- `cdb_valid_i` in CDB_W: writeback strobes.
- `cdb_id_i` in CDB_W×ID_W: target entries.
- `cdb_data_i` in CDB_W×DATA_W: results.
- `cdb_exc_i` in CDB_W: exception/mispredict flags.
- `commit_valid_o` out COMMIT_W: lane i is committable; always a prefix.
- `commit_info_o` out COMMIT_W×`rob_commit_t`: areg, pc, w_reg, w_mem, data, exc.
- `commit_ack_i` in COMMIT_W: lanes retired; must be a prefix subset of `commit_valid_o`.
- `count_o` out ID_W+1: occupied entries (registered).

## Operation
- Head and tail are ID_W+1-bit pointers; the MSB is the wrap bit.
- Empty: head == tail. Full: MSBs differ and low bits are equal.
- Accept condition: `disp_ready_o` = (DEPTH − count) ≥ DISPATCH_W, computed from registered count only.
- Allocation: on `disp_valid_i & disp_ready_o`, lane k writes entry tail+k and clears its complete and exc bits. Tail advances by popcount(disp_valid_i).
- CDB write: sets complete, stores data, and ORs exc into the target entry.
  - Writes to unallocated entries are illegal.
  - Two ports writing the same id in one cycle is illegal.
  - Both are checked by assertion.
- Commit lane i is valid when all of the following hold:
  - i < count;
  - entry head+i is complete;
  - every lane j<i is valid;
  - no lane j<i has exc set. An exception entry commits alone at its lane; younger lanes are gated.
- On ack, head advances by popcount(commit_ack_i).
- Count update: count_next = count + accepted dispatches − acks.
- Simultaneous dispatch and commit are both applied.
- Wrap-around is handled by natural pointer overflow.
- Flush and reset: head = tail = 0 and all complete bits = 0. Both take priority over same-cycle dispatch, CDB and ack.

## Timing
- Reset values:
  - `disp_ready_o` = 1, `commit_valid_o` = 0, `count_o` = 0, `src_complete_o` = 0.
  - `disp_id_o` = {DISPATCH_W−1..0}.
  - Data outputs are don't-care.
- Dispatch write to visible at commit or src lookup: 1 cycle.
- CDB write to visible at commit or src lookup: 1 cycle without bypass, 0 cycles with bypass (see Configuration).
- Ack to next-oldest entry presented: next cycle.
- Max throughput: DISPATCH_W allocations and COMMIT_W retirements per cycle.
- A full buffer with a same-cycle ack still deasserts ready that cycle; ready recovers the following cycle.

## Configuration
- `ROB_CDB_BYPASS_EN` defined: matching CDB writes are forwarded combinationally into `src_data_o`/`src_complete_o` and the commit lanes in the same cycle. A CDB write can therefore commit in the cycle it arrives.
- Undefined: no forwarding; all outputs come from stored state only, giving 1-cycle latency.

## Structure
- Shared `rob_pkg`:
  - `rob_inst_t`, `rob_commit_t`, `rob_data_t` (data + exc);
  - the `rob_ptr_t` width helper;
  - the default `ROB_DEPTH` constant.
- One sub-module, `rob_mp_regfile`: a parametrised multi-read, multi-write register array with R/W port counts and a write-lane mask. It is instantiated twice:
  - inst table: DISPATCH_W write ports;
  - data table: CDB_W write ports.
- Complete and exc bits are a flat register vector in the top level, because reset/flush must clear them.

## Test plan
- After reset, dispatch 2 instructions per cycle for 32 cycles with no CDB writes (DEPTH=64) → `disp_id_o` runs 0..63; ready drops when count=64; `commit_valid_o`=0.
- Dispatch ids 0,1; CDB writes id1 data 0xBEEF, then id0 data 0x1234 a cycle later → `commit_valid_o`=2'b11 only after id0 completes; data is 0x1234/0xBEEF.
- CDB write to id0 with exc=1; id1 also complete → `commit_valid_o`=2'b01; after ack, id1 is presented alone on lane 0.
- Fill to count 63, then retire and refill across index 63→0 → ids wrap to 0; full/empty flags are correct at each boundary.
- Assert flush while count=10 with same-cycle CDB and dispatch → next cycle count=0, ready=1, no commit_valid, ids restart at 0.
- With `ROB_CDB_BYPASS_EN`, a CDB write to the head entry → commit_valid is set in the same cycle; without the macro it is set one cycle later.
